// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1
//
// Two-requester arbiter in front of a shared size-bit datapath port. One requester
// is granted per transfer. Its data passes through a 2:1 select into a one-entry
// output register, which is presented downstream with a valid/ready handshake.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie.
//                       When undefined (the default), ties are broken round-robin.
//
// Ports:
//   clk_i     clock; all state changes on the rising edge
//   rst_i     synchronous, active-high reset
//   req0_i    requester 0 has data (held stable until granted)
//   data0_i   requester 0 data
//   gnt0_o    requester 0 transfer accepted this cycle (combinational)
//   req1_i    requester 1 has data (held stable until granted)
//   data1_i   requester 1 data
//   gnt1_o    requester 1 transfer accepted this cycle (combinational)
//   valid_o   data_o holds a transfer that has not yet been taken
//   data_o    registered selected data
//   select_o  source of the data in data_o
//   ready_i   downstream takes data_o this cycle when valid_o is high

module mux_arbiter_2to1 #(
    parameter int unsigned size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_i,
    input  logic [size-1:0] data0_i,
    output logic            gnt0_o,
    input  logic            req1_i,
    input  logic [size-1:0] data1_i,
    output logic            gnt1_o,
    output logic            valid_o,
    output logic [size-1:0] data_o,
    output logic            select_o,
    input  logic            ready_i
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e          state_q;
    logic [size-1:0] data_q;
    logic            select_q;
    logic            last_gnt_q;

    logic can_accept;
    logic win1;

    // The slot can take new data when it is empty, or when it drains this same cycle.
    assign can_accept = (state_q == StEmpty) || ready_i;

    always_comb begin
        win1 = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        win1 = !req0_i;
`else
        if (req0_i && req1_i) begin
            win1 = (last_gnt_q == 1'b0);
        end else begin
            win1 = req1_i;
        end
`endif
    end

    assign gnt0_o = can_accept && req0_i && !win1 && !rst_i;
    assign gnt1_o = can_accept && req1_i &&  win1 && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StEmpty;
            data_q     <= '0;
            select_q   <= 1'b0;
            // Requester 0 wins the first tie after reset.
            last_gnt_q <= 1'b1;
        end else if (gnt0_o || gnt1_o) begin
            state_q    <= StFull;
            data_q     <= gnt1_o ? data1_i : data0_i;
            select_q   <= gnt1_o;
            last_gnt_q <= gnt1_o;
        end else if (state_q == StFull && ready_i) begin
            // Drain without refill: data and select are kept, only valid drops.
            state_q <= StEmpty;
        end
    end

    assign valid_o  = (state_q == StFull);
    assign data_o   = data_q;
    assign select_o = select_q;

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
module tb_mux_arbiter_2to1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req0_i;
    logic [31:0] data0_i;
    logic        gnt0_o;
    logic        req1_i;
    logic [31:0] data1_i;
    logic        gnt1_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        select_o;
    logic        ready_i;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mux_arbiter_2to1 #(.size(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .req0_i   (req0_i),
        .data0_i  (data0_i),
        .gnt0_o   (gnt0_o),
        .req1_i   (req1_i),
        .data1_i  (data1_i),
        .gnt1_o   (gnt1_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .select_o (select_o),
        .ready_i  (ready_i)
    );

    typedef struct {
        logic        rst;
        logic        req0;
        logic [31:0] data0;
        logic        req1;
        logic [31:0] data1;
        logic        ready;
        logic        gnt0;
        logic        gnt1;
        logic        valid;
        logic [31:0] data;
        logic        sel;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive just after a rising edge, check grants before the next edge,
    // then check registered outputs just after that edge.
    task automatic apply(input vec_t v, input int idx);
        rst_i   = v.rst;
        req0_i  = v.req0;
        data0_i = v.data0;
        req1_i  = v.req1;
        data1_i = v.data1;
        ready_i = v.ready;
        #3;
        check("gnt0", idx, {31'b0, gnt0_o}, {31'b0, v.gnt0});
        check("gnt1", idx, {31'b0, gnt1_o}, {31'b0, v.gnt1});
        @(posedge clk);
        #1;
        check("valid", idx, {31'b0, valid_o}, {31'b0, v.valid});
        check("data", idx, data_o, v.data);
        check("select", idx, {31'b0, select_o}, {31'b0, v.sel});
    endtask

    initial begin
        //            rst   r0    d0            r1    d1     rdy   g0    g1    v     data          sel
        vecs[0]  = '{1'b1, 1'b1, 32'h0,        1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0};
`ifdef ARB_FIXED_PRIO_EN
        vecs[5]  = '{1'b0, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0};
`else
        vecs[5]  = '{1'b0, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       1'b1};
`endif
        // Backpressure: FULL with 0x11, requester 1 waits three cycles.
        vecs[8]  = '{1'b0, 1'b1, 32'h11,       1'b0, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h11,       1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,       1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h11,       1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,       1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h11,       1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,       1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h11,       1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       1'b1};
        // Drain without refill, then ready while EMPTY is ignored.
        vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h22,       1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h22,       1'b1};
        // EMPTY accepts regardless of ready.
        vecs[15] = '{1'b0, 1'b1, 32'h33,       1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h33,       1'b0};
        // Reset while FULL drops the data and denies the pending request.
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44,       1'b1};
        vecs[18] = '{1'b0, 1'b1, 32'h55,       1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44,       1'b1};

        rst_i   = 1'b1;
        req0_i  = 1'b0;
        req1_i  = 1'b0;
        data0_i = '0;
        data1_i = '0;
        ready_i = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i], i);
        end

        // Tie-breaking under intermittent backpressure, then requester 0 drops out.
        apply('{1'b1, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0}, 100);
        apply('{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0}, 101);
        apply('{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0}, 102);
`ifdef ARB_FIXED_PRIO_EN
        apply('{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0}, 103);
        apply('{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0}, 104);
`else
        apply('{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 1'b1}, 103);
        apply('{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0}, 104);
`endif
        apply('{1'b0, 1'b0, 32'hA0, 1'b1, 32'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 1'b1}, 105);
        apply('{1'b0, 1'b0, 32'hA0, 1'b0, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB0, 1'b1}, 106);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Grants must never be high together.
    always @(negedge clk) begin
        if (gnt0_o && gnt1_o) begin
            n_checks++;
            n_fails++;
            $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1, expected at most one");
        end
    end

endmodule
